// File: rtl/leds_pkg.sv
// Shared encodings for the LED pattern generator.
// Mode codes, scan direction and PWM counter width.
package leds_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_COUNT  = 2'd2,
        MODE_SCAN   = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam int PWM_W = 4;

endpackage

// File: rtl/leds_prescaler.sv
// Step prescaler: counts 0..DIV-1, pulses tick on the last count.
// clr restarts the count from zero on the next edge.
module leds_prescaler #(
    parameter int DIV = 12000000
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic         run_q;
    logic         wrap;

    assign wrap = (cnt_q == LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (clr || wrap) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + W'(1);
            end
        end
    end

    // run_q keeps tick low through reset even when DIV == 1
    assign tick = run_q & wrap;

endmodule

// File: rtl/leds_pattern.sv
// LED pattern generator: static, blink, binary count and bouncing scan.
// Define LEDS_PATTERN_PWM_EN to add a bright input with 4-bit PWM dimming.
module leds_pattern
    import leds_pkg::*;
#(
    parameter int N_LEDS = 8,
    parameter int DIV    = 12000000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [1:0]        mode,
    input  logic [N_LEDS-1:0] pattern,
`ifdef LEDS_PATTERN_PWM_EN
    input  logic [PWM_W-1:0]  bright,
`endif
    output logic [N_LEDS-1:0] leds,
    output logic              tick
);

    localparam int PW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam logic [PW-1:0] POS_TOP = PW'(N_LEDS - 1);

    mode_t             mode_i;
    mode_t             mode_q;
    logic              started_q;
    logic              entry;
    logic [N_LEDS-1:0] cnt_q;
    logic [N_LEDS-1:0] cnt_n;
    logic [PW-1:0]     pos_q;
    logic [PW-1:0]     pos_n;
    dir_t              dir_q;
    dir_t              dir_n;
    logic              phase_q;
    logic              phase_n;
    logic [N_LEDS-1:0] base_n;
    logic [N_LEDS-1:0] leds_n;

    assign mode_i = mode_t'(mode);
    // first edge after reset and any mode change both restart the mode
    assign entry  = !started_q || (mode_i != mode_q);

    leds_prescaler #(
        .DIV(DIV)
    ) u_prescaler (
        .clk (clk),
        .rstn(rstn),
        .clr (entry),
        .tick(tick)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            started_q <= 1'b0;
            mode_q    <= MODE_STATIC;
            cnt_q     <= '0;
            pos_q     <= '0;
            dir_q     <= DIR_UP;
            phase_q   <= 1'b1;
            leds      <= '0;
        end else begin
            started_q <= 1'b1;
            mode_q    <= mode_i;
            cnt_q     <= cnt_n;
            pos_q     <= pos_n;
            dir_q     <= dir_n;
            phase_q   <= phase_n;
            leds      <= leds_n;
        end
    end

    always_comb begin
        cnt_n   = cnt_q;
        pos_n   = pos_q;
        dir_n   = dir_q;
        phase_n = phase_q;
        if (entry) begin
            cnt_n   = '0;
            pos_n   = '0;
            dir_n   = DIR_UP;
            phase_n = 1'b1;
        end else if (tick) begin
            cnt_n   = cnt_q + N_LEDS'(1);
            phase_n = ~phase_q;
            if (N_LEDS > 1) begin
                if (dir_q == DIR_UP) begin
                    if (pos_q == POS_TOP) begin
                        pos_n = pos_q - PW'(1);
                        dir_n = DIR_DOWN;
                    end else begin
                        pos_n = pos_q + PW'(1);
                    end
                end else begin
                    if (pos_q == '0) begin
                        pos_n = PW'(1);
                        dir_n = DIR_UP;
                    end else begin
                        pos_n = pos_q - PW'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        base_n = '0;
        unique case (mode_i)
            MODE_STATIC: base_n = pattern;
            MODE_BLINK:  base_n = phase_n ? pattern : '0;
            MODE_COUNT:  base_n = cnt_n;
            MODE_SCAN:   base_n = N_LEDS'(1) << pos_n;
        endcase
    end

`ifdef LEDS_PATTERN_PWM_EN
    logic [PWM_W-1:0] pwm_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_q + PWM_W'(1);
        end
    end

    assign leds_n = (pwm_q < bright) ? base_n : '0;
`else
    assign leds_n = base_n;
`endif

endmodule

// File: doc/leds_pattern.md
LEDS_PATTERN -- requirements
Module: leds_pattern

Interface
REQ-001 Parameter N_LEDS, default 8: number of LED outputs, range 1..32.
REQ-002 Parameter DIV, default 12000000: clock cycles per pattern step, minimum 1 (12 MHz board clock gives a 1 Hz step).
REQ-003 clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 mode  input  2  pattern select: 0 STATIC, 1 BLINK, 2 COUNT, 3 SCAN.
REQ-006 pattern  input  N_LEDS  source pattern for the STATIC and BLINK modes.
REQ-007 leds  output  N_LEDS  registered LED drive; 1 means LED on.
REQ-008 tick  output  1  one-cycle pulse marking each pattern step.

Function
REQ-009 The prescaler SHALL count 0..DIV-1 and wrap, with tick=1 exactly in the cycle where count==DIV-1; with DIV=1, tick SHALL be constant 1 after reset.
REQ-010 The prescaler width SHALL be $clog2(DIV), with a minimum of 1 bit.
REQ-011 leds SHALL be registered; a state change caused by a tick SHALL appear on leds in the cycle after the tick.
REQ-012 STATIC: leds SHALL equal pattern delayed by one cycle; tick SHALL be ignored.
REQ-013 BLINK: a phase bit SHALL toggle on each tick; leds=pattern when the phase is 1, else all zeros; pattern changes SHALL be reflected within one cycle.
REQ-014 COUNT: an N_LEDS-bit counter SHALL increment on each tick and wrap from all-ones to zero; leds=counter.
REQ-015 SCAN: leds SHALL be one-hot; the position SHALL step by one per tick and bounce at the ends without dwelling (sequence 0,1..N_LEDS-1,N_LEDS-2..1,0,1..).
REQ-016 With N_LEDS=1, SCAN SHALL hold leds=1 permanently.
REQ-017 The cycle after mode changes value SHALL be a mode-entry cycle, in which all of the following SHALL happen:
- prescaler=0;
- counter=0;
- scan position=0, direction=up;
- blink phase=1.
REQ-018 A mode change and a tick in the same cycle SHALL resolve to mode entry; the tick SHALL still pulse.
REQ-019 Mode state SHALL NOT be retained across mode changes.

Reset
REQ-020 While rstn=0, all of the following SHALL hold immediately and independent of clk:
- leds=0;
- tick=0;
- prescaler=0;
- counter=0;
- scan position=0, direction=up;
- blink phase=1.
REQ-021 Reset SHALL be usable mid-operation in any mode and SHALL leave no residual state.
REQ-022 The first rising clk edge after rstn deasserts SHALL act as a mode-entry cycle for the current mode.

Configuration
REQ-023 Macro LEDS_PATTERN_PWM_EN: when defined, the block SHALL add input bright[3:0] and a free-running 4-bit PWM counter, with each LED lit only while its pattern bit is 1 and pwm_cnt < bright.
REQ-024 Under LEDS_PATTERN_PWM_EN, bright=0 SHALL force leds off.
REQ-025 Under LEDS_PATTERN_PWM_EN, bright=15 SHALL give a 15/16 duty cycle.
REQ-026 Under LEDS_PATTERN_PWM_EN, the PWM counter SHALL reset to 0.
REQ-027 When LEDS_PATTERN_PWM_EN is not defined, there SHALL be no bright port and no PWM logic, and leds SHALL follow REQ-012..REQ-016 directly.

Structure
REQ-028 Shared package leds_pkg SHALL hold the mode encodings MODE_STATIC, MODE_BLINK, MODE_COUNT and MODE_SCAN, plus the PWM counter width constant.
REQ-029 The prescaler SHALL be sub-module leds_prescaler, with parameter DIV, inputs clk, rstn and clr, and output tick; the remaining logic SHALL stay in leds_pattern.

Verification
All scenarios use N_LEDS=8, DIV=4 unless stated.
REQ-030 Reset: mode=2 running, pull rstn low between clocks -> leds=8'h00 and tick=0 before the next edge; release -> count restarts at 8'h00.
REQ-031 STATIC: mode=0, pattern=8'hA5 -> leds=8'hA5 one cycle later; pattern to 8'h3C -> leds=8'h3C next cycle.
REQ-032 COUNT wrap: mode=2, run 1024 cycles -> leds steps 00,01,02.. every 4 cycles, one cycle after each tick, and goes FF->00.
REQ-033 SCAN bounce: mode=3 -> leds 01,02,04..80,40,20..01,02, each value held 4 cycles, with no repeat of 80 or 01.
REQ-034 Mode change coincident with tick: COUNT at 8'h05, switch to BLINK with pattern=8'h0F on a tick cycle -> leds=8'h0F, then 8'h00 four cycles later.
REQ-035 PWM (LEDS_PATTERN_PWM_EN defined): mode=0, pattern=8'hFF, bright=4 -> each LED on for exactly 4 of every 16 cycles; bright=0 -> always off.
